move_executor: RTL

MOVE_EXECUTOR -- requirements
Module: move_executor

---
 rtl/move_executor.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/move_executor.sv
`default_nettype none
// ---- move_executor : executes one Othello move (validate, walk 8 rays, reverse, place) ----
// ---- rev 1.0 ---------------------------------------------------------------------------------
module move_executor (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] mv_x,
  input  logic [2:0] mv_y,
  input  logic       is_black,
  output logic [2:0] rd_x,
  output logic [2:0] rd_y,
  input  logic [2:0] rd_state,
  output logic [2:0] wr_x,
  output logic [2:0] wr_y,
  output logic       wr_play,
  output logic       wr_reverse,
  output logic       wr_set_black,
  output logic       busy,
  output logic       done,
  output logic       valid_move,
  output logic [5:0] flip_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_WALK   = 3'd2;
  localparam logic [2:0] S_FLIP   = 3'd3;
  localparam logic [2:0] S_PLACE  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [2:0] NODE_ENABLE = 3'b100;
  localparam logic [2:0] NODE_BLACK  = 3'b111;
  localparam logic [2:0] NODE_WHITE  = 3'b110;

  logic [2:0] state, state_n;
  logic [2:0] tgt_x, tgt_x_n, tgt_y, tgt_y_n;
  logic       colour, colour_n;
  logic [2:0] dir, dir_n;
  logic [3:0] pos_x, pos_x_n, pos_y, pos_y_n;
  logic [2:0] run, run_n;
  logic [5:0] flip_count_n;
  logic       valid_n;
  logic       advance;
  logic       oob;
  logic       is_own, is_opp;
  logic [3:0] tgt_x4, tgt_y4;
  logic [2:0] dir_inc;

  // Two's-complement unit steps, indexed by direction 0..7 (N, NE, E, SE, S, SW, W, NW).
  function automatic logic [3:0] step_x(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: step_x = 4'b0001;
      3'd5, 3'd6, 3'd7: step_x = 4'b1111;
      default:          step_x = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] step_y(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: step_y = 4'b1111;
      3'd3, 3'd4, 3'd5: step_y = 4'b0001;
      default:          step_y = 4'b0000;
    endcase
  endfunction

  assign tgt_x4  = {1'b0, tgt_x};
  assign tgt_y4  = {1'b0, tgt_y};
  assign dir_inc = dir + 3'd1;
  // A ray never steps more than one cell past the board, so bit 3 flags both -1 and 8.
  assign oob     = pos_x[3] | pos_y[3];
  assign is_own  = (rd_state == (colour ? NODE_BLACK : NODE_WHITE));
  assign is_opp  = (rd_state == (colour ? NODE_WHITE : NODE_BLACK));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      tgt_x      <= 3'd0;
      tgt_y      <= 3'd0;
      colour     <= 1'b0;
      dir        <= 3'd0;
      pos_x      <= 4'd0;
      pos_y      <= 4'd0;
      run        <= 3'd0;
      flip_count <= 6'd0;
      valid_move <= 1'b0;
    end else begin
      state      <= state_n;
      tgt_x      <= tgt_x_n;
      tgt_y      <= tgt_y_n;
      colour     <= colour_n;
      dir        <= dir_n;
      pos_x      <= pos_x_n;
      pos_y      <= pos_y_n;
      run        <= run_n;
      flip_count <= flip_count_n;
      valid_move <= valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    tgt_x_n      = tgt_x;
    tgt_y_n      = tgt_y;
    colour_n     = colour;
    dir_n        = dir;
    pos_x_n      = pos_x;
    pos_y_n      = pos_y;
    run_n        = run;
    flip_count_n = flip_count;
    valid_n      = valid_move;
    advance      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          tgt_x_n      = mv_x;
          tgt_y_n      = mv_y;
          colour_n     = is_black;
          flip_count_n = 6'd0;
          valid_n      = 1'b0;
          dir_n        = 3'd0;
          state_n      = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rd_state == NODE_ENABLE) begin
          state_n = S_WALK;
          pos_x_n = tgt_x4 + step_x(3'd0);
          pos_y_n = tgt_y4 + step_y(3'd0);
          run_n   = 3'd0;
        end else begin
          state_n = S_FINISH;
        end
      end
      S_WALK: begin
        if (oob || !(is_own || is_opp)) begin
          advance = 1'b1;
        end else if (is_opp) begin
          run_n   = run + 3'd1;
          pos_x_n = pos_x + step_x(dir);
          pos_y_n = pos_y + step_y(dir);
        end else if (run != 3'd0) begin
          // Rewind to k=1 and replay the run as reverse commands.
          state_n = S_FLIP;
          pos_x_n = tgt_x4 + step_x(dir);
          pos_y_n = tgt_y4 + step_y(dir);
        end else begin
          advance = 1'b1;
        end
      end
      S_FLIP: begin
        flip_count_n = flip_count + 6'd1;
        pos_x_n      = pos_x + step_x(dir);
        pos_y_n      = pos_y + step_y(dir);
        run_n        = run - 3'd1;
        if (run == 3'd1) begin
          advance = 1'b1;
        end
      end
      S_PLACE: begin
        valid_n = 1'b1;
        state_n = S_FINISH;
      end
      S_FINISH: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (advance) begin
      if (dir == 3'd7) begin
        // Leaving FLIP means at least one flip happened even though flip_count lags by one.
        state_n = ((flip_count != 6'd0) || (state == S_FLIP)) ? S_PLACE : S_FINISH;
      end else begin
        dir_n   = dir_inc;
        state_n = S_WALK;
        pos_x_n = tgt_x4 + step_x(dir_inc);
        pos_y_n = tgt_y4 + step_y(dir_inc);
        run_n   = 3'd0;
      end
    end
  end

  always_comb begin
    rd_x         = 3'd0;
    rd_y         = 3'd0;
    wr_x         = 3'd0;
    wr_y         = 3'd0;
    wr_play      = 1'b0;
    wr_reverse   = 1'b0;
    wr_set_black = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_CHECK: begin
        busy = 1'b1;
        rd_x = tgt_x;
        rd_y = tgt_y;
      end
      S_WALK: begin
        busy = 1'b1;
        if (!oob) begin
          rd_x = pos_x[2:0];
          rd_y = pos_y[2:0];
        end
      end
      S_FLIP: begin
        busy         = 1'b1;
        wr_x         = pos_x[2:0];
        wr_y         = pos_y[2:0];
        wr_play      = 1'b1;
        wr_reverse   = 1'b1;
        wr_set_black = colour;
      end
      S_PLACE: begin
        busy         = 1'b1;
        wr_x         = tgt_x;
        wr_y         = tgt_y;
        wr_play      = 1'b1;
        wr_set_black = colour;
      end
      S_FINISH: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire
